// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the shared FIFO write port. A local credit count of
// free FIFO slots gates every write, so the FIFO's own full flag is never consulted.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_data,
    input  logic                 credit_ret,
    output logic [CW-1:0]        credits,
    output logic                 credit_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] elig_p0;
    logic [DW-1:0]   req_arr [NREQ];
    logic [PW-1:0]   win_p0;
    logic            found_p0;
    logic [PW:0]     idx_p0;
    logic            issue_p0;
    logic            ovf_p0;
    logic [CW-1:0]   credits_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_arr[i] = req_data[i*DW +: DW];
    end

    // Arbitration stage: a requester granted this cycle sits out until it can update req.
    assign elig_p0 = req & ~gnt;

    always_comb begin
        win_p0   = '0;
        found_p0 = 1'b0;
        idx_p0   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_p0 = {1'b0, ptr} + (PW+1)'(k);
            if (idx_p0 >= (PW+1)'(NREQ)) begin
                idx_p0 = idx_p0 - (PW+1)'(NREQ);
            end
            if (!found_p0 && elig_p0[idx_p0[PW-1:0]]) begin
                win_p0   = idx_p0[PW-1:0];
                found_p0 = 1'b1;
            end
        end
    end

    assign issue_p0 = (credits != '0) && (elig_p0 != '0);
    assign ovf_p0   = credit_ret && !issue_p0 && (credits == CRED_MAX);

    // An issue and a returned credit in the same cycle cancel; a return at full count is dropped.
    always_comb begin
        credits_nxt = credits;
        if (issue_p0 && !credit_ret) begin
            credits_nxt = credits - 1'b1;
        end else if (!issue_p0 && credit_ret && !ovf_p0) begin
            credits_nxt = credits + 1'b1;
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt        <= '0;
            fifo_wr    <= 1'b0;
            fifo_data  <= '0;
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
            ptr        <= '0;
        end else begin
            fifo_wr <= issue_p0;
            gnt     <= issue_p0 ? (NREQ'(1) << win_p0) : '0;
            if (issue_p0) begin
                fifo_data <= req_arr[win_p0];
                ptr       <= (win_p0 == LAST_IDX) ? '0 : win_p0 + 1'b1;
            end
            credits <= credits_nxt;
            if (ovf_p0) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a behavioural model predicts every cycle's outputs into a
// scoreboard queue; a negedge monitor pops and compares, and logs every FIFO write.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic                fifo_wr;
    logic [DW-1:0]       fifo_data;
    logic                credit_ret;
    logic [CW-1:0]       credits;
    logic                credit_err;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .credit_ret (credit_ret),
        .credits    (credits),
        .credit_err (credit_err)
    );

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            wr;
        logic [DW-1:0]   data;
        int              cred;
        logic            err;
    } exp_t;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wlog[$];
    exp_t mon_e;
    wr_t  mon_w;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int mark;

    // Reference model state
    logic [NREQ-1:0] m_gnt;
    logic            m_wr;
    logic [DW-1:0]   m_data;
    int              m_cred;
    int              m_ptr;
    logic            m_err;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, want, edge_n);
        end
    endtask

    // Monitor: compare the registered outputs of the cycle just begun, log writes.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gnt",        32'(gnt),        32'(mon_e.gnt));
            check("fifo_wr",    32'(fifo_wr),    32'(mon_e.wr));
            check("fifo_data",  32'(fifo_data),  32'(mon_e.data));
            check("credits",    32'(credits),    32'(mon_e.cred));
            check("credit_err", 32'(credit_err), 32'(mon_e.err));
        end
        if (fifo_wr === 1'b1) begin
            mon_w.cyc  = edge_n;
            mon_w.gnt  = gnt;
            mon_w.data = fifo_data;
            wlog.push_back(mon_w);
        end
    end

    // Applies the arbitration and credit rules to the inputs seen at this edge.
    task automatic model_step();
        int   win;
        exp_t e;
        if (!reset) begin
            m_gnt  = '0;
            m_wr   = 1'b0;
            m_data = '0;
            m_cred = DEPTH;
            m_err  = 1'b0;
            m_ptr  = 0;
        end else begin
            win = -1;
            if (m_cred != 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i = (m_ptr + k) % NREQ;
                    if (win < 0 && req[i] && !m_gnt[i]) win = i;
                end
            end
            if (win >= 0 && credit_ret) begin
                m_cred = m_cred;
            end else if (win >= 0) begin
                m_cred = m_cred - 1;
            end else if (credit_ret) begin
                if (m_cred == DEPTH) m_err = 1'b1;
                else m_cred = m_cred + 1;
            end
            if (win >= 0) begin
                m_gnt  = NREQ'(1 << win);
                m_wr   = 1'b1;
                m_data = req_data[win*DW +: DW];
                m_ptr  = (win + 1) % NREQ;
            end else begin
                m_gnt = '0;
                m_wr  = 1'b0;
            end
        end
        e.gnt  = m_gnt;
        e.wr   = m_wr;
        e.data = m_data;
        e.cred = m_cred;
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    // Requesters obey the contract: hold until granted, then drop or present new data.
    task automatic upd_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && m_gnt[i]) begin
                if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                else req_data[i*DW +: DW] = DW'($urandom);
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                req[i] = 1'b1;
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        req        = '0;
        req_data   = '0;
        credit_ret = 1'b0;

        // Reset held with every requester asserting
        wlog.delete();
        req = '1;
        do_reset(2);
        settle();
        check("no_write_in_reset", 32'(wlog.size()), 32'd0);

        // Round-robin rotation with a credit returned every cycle
        req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        credit_ret = 1'b1;
        wlog.delete();
        repeat (5) step();
        settle();
        check("rr_count", 32'(wlog.size()), 32'd5);
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            check("rr_gnt",  32'(wlog[k].gnt),  32'(1 << (k % 4)));
            check("rr_data", 32'(wlog[k].data), 32'h10 + 32'(k % 4));
        end
        req        = '0;
        credit_ret = 1'b0;
        step();

        // Lone requester: granted only every other cycle
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'hA5;
        wlog.delete();
        repeat (10) begin
            credit_ret = (m_cred < DEPTH);
            step();
        end
        settle();
        check("single_count", 32'(wlog.size()), 32'd5);
        for (int k = 0; k < wlog.size(); k++) begin
            check("single_gnt", 32'(wlog[k].gnt), 32'b0100);
            if (k > 0) check("single_spacing", 32'(wlog[k].cyc - wlog[k-1].cyc), 32'd2);
        end
        req        = '0;
        credit_ret = 1'b0;
        step();

        // Credit exhaustion, then a single returned credit
        do_reset(1);
        req      = '1;
        req_data = {8'h43, 8'h42, 8'h41, 8'h40};
        wlog.delete();
        repeat (12) step();
        settle();
        check("exhaust_writes", 32'(wlog.size()), 32'd8);
        check("exhaust_credits", 32'(credits), 32'd0);
        wlog.delete();
        credit_ret = 1'b1;
        step();
        mark = edge_n;
        credit_ret = 1'b0;
        repeat (3) step();
        settle();
        check("one_credit_writes", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) check("one_credit_edge", 32'(wlog[0].cyc), 32'(mark + 1));

        // Return at zero, then returns coinciding with issues at one credit
        credit_ret = 1'b1;
        repeat (4) step();
        credit_ret = 1'b0;
        req = '0;
        step();

        // Overflow: sticky until reset
        do_reset(1);
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        repeat (3) step();
        settle();
        check("err_sticky", 32'(credit_err), 32'd1);
        do_reset(1);
        step();

        // Reset during back-to-back writes at three credits
        req      = '1;
        req_data = {8'h73, 8'h72, 8'h71, 8'h70};
        repeat (5) step();
        settle();
        check("pre_reset_credits", 32'(credits), 32'd3);
        do_reset(1);
        wlog.delete();
        step();
        settle();
        check("restart_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) check("restart_gnt", 32'(wlog[0].gnt), 32'b0001);
        req = '0;
        step();

        // Randomized traffic with randomly returned credits
        do_reset(1);
        repeat (400) begin
            upd_reqs();
            credit_ret = (m_cred < DEPTH) && ($urandom_range(0, 2) == 0);
            step();
        end
        req        = '0;
        credit_ret = 1'b0;
        step();
        settle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
